// File: rtl/periph_arb_pkg.sv
// Shared types and the round-robin search helper for periph_tx_arbiter.
package periph_arb_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned PAY_W  = 32 - ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PAY_W-1:0]  payload;
    } arb_word_t;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

    // First set bit of valid[n-1:0] searching upward from last+1 with wrap; last if none.
    function automatic int unsigned rr_next(input logic [31:0] valid, input int unsigned n,
                                            input int unsigned last);
        int unsigned idx;
        logic        found;
        rr_next = last;
        found   = 1'b0;
        for (int unsigned k = 1; k <= 32; k++) begin
            idx = (last + k) % n;
            if (k <= n && !found && valid[idx[4:0]]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/periph_arb_skid.sv
// Two-entry first-word-fall-through buffer; dout reads zero while empty.
module periph_arb_skid #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         space,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         not_empty
);

    logic [W-1:0] e0_q, e1_q;
    logic [1:0]   cnt_q;
    logic         rd;

    assign not_empty = (cnt_q != 2'd0);
    assign rd        = pop && not_empty;
    // A read in the same cycle frees a slot, so a full buffer can still accept a push.
    assign space     = (cnt_q < 2'd2) || pop;
    assign dout      = not_empty ? e0_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push) begin
                        e0_q  <= din;
                        cnt_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && rd) begin
                        e0_q <= din;
                    end else if (push) begin
                        e1_q  <= din;
                        cnt_q <= 2'd2;
                    end else if (rd) begin
                        cnt_q <= 2'd0;
                    end
                end
                default: begin
                    if (rd) begin
                        e0_q <= e1_q;
                        if (push) begin
                            e1_q <= din;
                        end else begin
                            cnt_q <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/periph_tx_arbiter.sv
// Round-robin bounded-burst merge of N peripheral TX streams toward the FT601 controller.
// Define PERIPH_ARB_STATS_EN to add per-port popped-word counters (stat_words, stat_clr).
module periph_tx_arbiter #(
    parameter int unsigned N_PERIPH  = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_PERIPH-1:0]              periph_valid,
    input  logic [N_PERIPH*(32-ADDR_W)-1:0]  periph_data,
    output logic [N_PERIPH-1:0]              periph_ready,
    output logic                             periph_data_available,
    input  logic                             read_periph_data,
    output logic [31:0]                      data_i,
    output logic [3:0]                       i_valid
`ifdef PERIPH_ARB_STATS_EN
    ,
    input  logic                             stat_clr,
    output logic [N_PERIPH*16-1:0]           stat_words
`endif
);
    import periph_arb_pkg::*;

    localparam int unsigned PAY_W = 32 - ADDR_W;
    localparam int unsigned GW    = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;
    localparam int unsigned CW    = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d, last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PAY_W-1:0] pay_arr [N_PERIPH];
    logic             space, take, not_empty;
    logic [31:0]      push_word;

    always_comb begin
        for (int i = 0; i < N_PERIPH; i++) begin
            pay_arr[i] = periph_data[i*PAY_W +: PAY_W];
        end
    end

    assign push_word = {ADDR_W'(grant_q), pay_arr[grant_q]};

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        take         = 1'b0;
        periph_ready = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (|periph_valid) begin
                    grant_d = GW'(rr_next(32'(periph_valid), N_PERIPH, 32'(last_q)));
                    state_d = ARB_BURST;
                end
            end
            ARB_BURST: begin
                if (!periph_valid[grant_q]) begin
                    state_d = ARB_IDLE;
                    last_d  = grant_q;
                    cnt_d   = '0;
                end else if (space) begin
                    take                  = 1'b1;
                    periph_ready[grant_q] = 1'b1;
                    if (cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d = ARB_IDLE;
                        last_d  = grant_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= GW'(N_PERIPH - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    periph_arb_skid #(
        .W (32)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (take),
        .din       (push_word),
        .space     (space),
        .pop       (read_periph_data),
        .dout      (data_i),
        .not_empty (not_empty)
    );

    assign periph_data_available = not_empty;
    assign i_valid               = {4{not_empty}};

`ifdef PERIPH_ARB_STATS_EN
    logic [15:0] stat_q [N_PERIPH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PERIPH; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_PERIPH; i++) begin
                if (stat_clr) begin
                    stat_q[i] <= '0;
                end else if (periph_ready[i] && stat_q[i] != 16'hFFFF) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_PERIPH; i++) stat_words[i*16 +: 16] = stat_q[i];
    end
`endif

endmodule
